fetch_ctrl: RTL and testbench

Fetch-stage sequencer that owns the program counter and drives a multi-cycle instruction memory through a req/ready handshake. It presents fetched instructions to decode through a registered IF/ID stage with a valid bit. It applies taken-branch redirects from the branch-resolution stage, stalls on decode back-pressure with a one-entry skid buffer, and never loses or duplicates an instruction. It sits between the PC/instruction-memory datapath and the decode stage.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid_buffer.sv | 45 ++++
 rtl/fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry instr/PC holding register. It catches a fetch that lands while
// decode is stalled. Clear wins over load, and load wins over unload.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            resetn,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  // Capture on load. Drop the entry on clear or unload.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer. It owns the PC and drives instruction memory over a
// req/ready handshake. It feeds decode through a registered IF/ID stage and
// handles branch redirects and decode back-pressure.
// Optional build macro FETCH_PERF_EN adds fetched/stall performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            resetn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            id_stall,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cycles
`endif
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q, pend_q, ifp_q;
  logic [31:0]     ifi_q;
  logic            ifv_q, req_q;

  logic            xfer, loadable, consumed;
  logic            skid_load, skid_unload, skid_v;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc, pc_plus4, redir_pc;

  // Handshake and IF/ID occupancy. A redirect target is always word aligned.
  always_comb begin
    xfer        = req_q && imem_ready;
    loadable    = !ifv_q || !id_stall;
    consumed    = ifv_q && !id_stall;
    pc_plus4    = pc_q + XLEN'(INSTR_BYTES);
    redir_pc    = branch_target & ~(XLEN'(INSTR_BYTES - 1));
    skid_load   = !branch_taken && (state_q == REQ) && xfer && !loadable;
    skid_unload = !branch_taken && (state_q == HOLD) && !id_stall;
  end

  fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
    .CLK      (CLK),
    .resetn   (resetn),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (branch_taken),
    .instr_i  (imem_rdata),
    .pc_i     (pc_q),
    .valid_o  (skid_v),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  // Main sequencer. A redirect pre-empts everything. A request that is still
  // in flight must be completed at its stale address, and its data dropped,
  // before the target is fetched.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      req_q   <= 1'b0;
      ifv_q   <= 1'b0;
      ifi_q   <= NOP_INSTR;
      ifp_q   <= '0;
    end else if (branch_taken) begin
      ifv_q <= 1'b0;
      case (state_q)
        REQ: begin
          if (xfer) pc_q <= redir_pc;
          else begin
            pend_q  <= redir_pc;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer) begin
            pc_q    <= redir_pc;
            state_q <= REQ;
          end else pend_q <= redir_pc;
        end
        default: begin
          pc_q    <= redir_pc;
          state_q <= REQ;
          req_q   <= 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (xfer) begin
            pc_q <= pc_plus4;
            if (loadable) begin
              ifv_q <= 1'b1;
              ifi_q <= imem_rdata;
              ifp_q <= pc_q;
            end else begin
              state_q <= HOLD;
              req_q   <= 1'b0;
            end
          end else if (consumed) ifv_q <= 1'b0;
        end
        HOLD: begin
          if (!id_stall) begin
            ifv_q   <= skid_v;
            ifi_q   <= skid_instr;
            ifp_q   <= skid_pc;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (consumed) ifv_q <= 1'b0;
          if (xfer) begin
            pc_q    <= pend_q;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign fetch_pc    = pc_q;
  assign if_id_valid = ifv_q;
  assign if_id_instr = ifi_q;
  assign if_id_pc    = ifp_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;
  logic        if_load;

  assign if_load = !branch_taken &&
                   (((state_q == REQ) && xfer && loadable) || skid_unload);

  // Count instructions entering IF/ID and cycles decode holds a live one.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (if_load)           perf_fetched_q <= perf_fetched_q + 32'd1;
      if (ifv_q && id_stall) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl. It runs a cycle table for reset and handshake
// timing, then scoreboarded scenarios for wait states, stalls, redirects,
// PC wrap and reset during a drain.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0, man_rdy = 1'b0, auto_rdy = 1'b0, auto_mem = 1'b0;
  logic        branch_taken = 1'b0, id_stall = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_ready, imem_req, if_id_valid;
  logic [31:0] imem_rdata, imem_addr, if_id_instr, if_id_pc, fetch_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
`endif

  int total = 0, bad = 0;
  int xfer_cnt = 0, deliv_cnt = 0, nwait = 0, wcnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc = '0, pend = '0, p;
  bit          stale = 1'b0;

  always #5 CLK = ~CLK;

  // Memory returns the inverted address as the instruction word.
  assign imem_rdata = ~imem_addr;
  assign imem_ready = auto_mem ? auto_rdy : man_rdy;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_stall(id_stall),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .fetch_pc(fetch_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Wait-state memory: ready rises after nwait cycles of an open request.
  always @(negedge CLK) auto_rdy = imem_req && (wcnt >= nwait);

  // Scoreboard and reference PC. This block samples just before each rising edge.
  // Kept fetches are pushed when they transfer and popped when decode consumes.
  // A redirect flushes everything not yet consumed.
  always begin
    @(negedge CLK);
    #4;
    if (!resetn) begin
      sb_q.delete();
      stale  = 1'b0;
      exp_pc = '0;
      wcnt   = 0;
    end else begin
      if (if_id_valid && !id_stall) begin
        deliv_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_spurious: got pc %h want no instruction", if_id_pc);
        end else begin
          p = sb_q.pop_front();
          chk("sb_pc", if_id_pc, p);
          chk("sb_instr", if_id_instr, ~p);
        end
      end
      if (imem_req) chk("fetch_addr", imem_addr, exp_pc);
      if (imem_req && imem_ready) begin
        xfer_cnt++;
        if (branch_taken) begin
          exp_pc = branch_target & ~32'd3;
          stale  = 1'b0;
        end else if (stale) begin
          exp_pc = pend;
          stale  = 1'b0;
        end else begin
          sb_q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end else if (branch_taken) begin
        if (imem_req) begin
          stale = 1'b1;
          pend  = branch_target & ~32'd3;
        end else exp_pc = branch_target & ~32'd3;
      end
      if (branch_taken) sb_q.delete();
      wcnt = (imem_req && !imem_ready) ? wcnt + 1 : 0;
    end
  end

  typedef struct {
    logic rstn, rdy, stall, br;
    logic [31:0] tgt;
    logic req, vld;
    logic [31:0] instr, ifpc, fpc;
  } vec_t;

  vec_t tbl[16];

  task automatic do_reset(input int nw);
    resetn = 1'b0; branch_taken = 1'b0; id_stall = 1'b0;
    auto_mem = 1'b1; nwait = nw;
    tick(); tick();
    resetn = 1'b1;
  endtask

  initial begin
    int n, x0, d0;
    // Each row gives the inputs at one edge and the outputs after that edge.
    tbl[0]  = '{0,0,0,0,32'h0,   0,0,NOP,         32'h0,  32'h0};
    tbl[1]  = '{1,0,0,0,32'h0,   1,0,NOP,         32'h0,  32'h0};
    tbl[2]  = '{1,1,0,0,32'h0,   1,1,32'hFFFFFFFF,32'h0,  32'h4};
    tbl[3]  = '{1,1,0,0,32'h0,   1,1,32'hFFFFFFFB,32'h4,  32'h8};
    tbl[4]  = '{1,1,1,0,32'h0,   0,1,32'hFFFFFFFB,32'h4,  32'hC};
    tbl[5]  = '{1,0,1,0,32'h0,   0,1,32'hFFFFFFFB,32'h4,  32'hC};
    tbl[6]  = '{1,0,0,0,32'h0,   1,1,32'hFFFFFFF7,32'h8,  32'hC};
    tbl[7]  = '{1,1,1,1,32'h103, 1,0,32'hFFFFFFF7,32'h8,  32'h100};
    tbl[8]  = '{1,0,0,0,32'h0,   1,0,32'hFFFFFFF7,32'h8,  32'h100};
    tbl[9]  = '{1,1,0,0,32'h0,   1,1,32'hFFFFFEFF,32'h100,32'h104};
    tbl[10] = '{1,0,0,1,32'h200, 1,0,32'hFFFFFEFF,32'h100,32'h104};
    tbl[11] = '{1,0,0,0,32'h0,   1,0,32'hFFFFFEFF,32'h100,32'h104};
    tbl[12] = '{1,1,0,0,32'h0,   1,0,32'hFFFFFEFF,32'h100,32'h200};
    tbl[13] = '{1,1,0,0,32'h0,   1,1,32'hFFFFFDFF,32'h200,32'h204};
    tbl[14] = '{1,0,1,0,32'h0,   1,1,32'hFFFFFDFF,32'h200,32'h204};
    tbl[15] = '{1,0,0,0,32'h0,   1,0,32'hFFFFFDFF,32'h200,32'h204};

    tick();
    for (int i = 0; i < 16; i++) begin
      resetn = tbl[i].rstn; man_rdy = tbl[i].rdy; id_stall = tbl[i].stall;
      branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
      tick();
      chk($sformatf("t%0d_req", i),   32'(imem_req),    32'(tbl[i].req));
      chk($sformatf("t%0d_vld", i),   32'(if_id_valid), 32'(tbl[i].vld));
      chk($sformatf("t%0d_instr", i), if_id_instr,      tbl[i].instr);
      chk($sformatf("t%0d_ifpc", i),  if_id_pc,         tbl[i].ifpc);
      chk($sformatf("t%0d_fpc", i),   fetch_pc,         tbl[i].fpc);
    end
    branch_taken = 1'b0; id_stall = 1'b0; man_rdy = 1'b0;

    // With 2 wait states, each fetch takes 3 cycles.
    do_reset(2);
    n = 0;
    while (!(imem_req && imem_ready) && n < 50) begin tick(); n++; end
    chk("s1_start_timeout", 32'(n < 50), 32'd1);
    x0 = xfer_cnt; d0 = deliv_cnt;
    repeat (30) tick();
    chk("s1_xfers", 32'(xfer_cnt - x0), 32'd10);
    chk("s1_deliv", 32'(deliv_cnt - d0), 32'd10);

    // A 4-cycle stall during the transfer of 0x8 parks it in the skid buffer.
    do_reset(0);
    n = 0;
    while (!(if_id_valid && if_id_pc == 32'h4) && n < 50) begin tick(); n++; end
    chk("s2_start_timeout", 32'(n < 50), 32'd1);
    id_stall = 1'b1;
    tick();
    chk("s2_hold_req", 32'(imem_req), 32'd0);
    chk("s2_hold_ifpc", if_id_pc, 32'h4);
    repeat (3) tick();
    id_stall = 1'b0;
    tick();
    chk("s2_unload_vld", 32'(if_id_valid), 32'd1);
    chk("s2_unload_ifpc", if_id_pc, 32'h8);
    repeat (6) tick();

    // A redirect while a 2-wait fetch of 0xC is outstanding goes through DRAIN.
    do_reset(2);
    n = 0;
    while (!(imem_req && imem_addr == 32'hC && !imem_ready) && n < 50) begin tick(); n++; end
    chk("s3_start_timeout", 32'(n < 50), 32'd1);
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    chk("s3_drain_req", 32'(imem_req), 32'd1);
    chk("s3_drain_addr", imem_addr, 32'hC);
    n = 0;
    while (imem_addr != 32'h100 && n < 20) begin
      chk("s3_flush_vld", 32'(if_id_valid), 32'd0);
      tick(); n++;
    end
    chk("s3_target_timeout", 32'(n < 20), 32'd1);
    n = 0;
    while (!if_id_valid && n < 20) begin tick(); n++; end
    chk("s3_target_ifpc", if_id_pc, 32'h100);

    // The redirect target drops its low bits, and the next PC wraps to 0.
    do_reset(0);
    n = 0;
    while (!if_id_valid && n < 50) begin tick(); n++; end
    chk("s4_start_timeout", 32'(n < 50), 32'd1);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    chk("s4_fpc_top", fetch_pc, 32'hFFFF_FFFC);
    tick();
    chk("s4_wrap_addr", imem_addr, 32'h0);
    chk("s4_wrap_vld", 32'(if_id_valid), 32'd1);
    chk("s4_wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    repeat (3) tick();

    // Asserting reset in the middle of DRAIN returns everything to reset values.
    do_reset(3);
    n = 0;
    while (!(imem_req && !imem_ready) && n < 50) begin tick(); n++; end
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    chk("s5_drain_req", 32'(imem_req), 32'd1);
    resetn = 1'b0;
    tick();
    chk("s5_rst_req", 32'(imem_req), 32'd0);
    chk("s5_rst_vld", 32'(if_id_valid), 32'd0);
    chk("s5_rst_fpc", fetch_pc, 32'h0);
    chk("s5_rst_instr", if_id_instr, NOP);
    resetn = 1'b1;
    n = 0;
    while (!if_id_valid && n < 50) begin tick(); n++; end
    chk("s5_refetch_timeout", 32'(n < 50), 32'd1);
    chk("s5_refetch_ifpc", if_id_pc, 32'h0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
